// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per cycle, least significant digit first.
// Optional subtract path is compiled in by defining BCD_SUB_EN.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = $clog2(DIGITS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state;
    logic [W-1:0]    x_sh;
    logic [W-1:0]    y_sh;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            sub_r;

    logic            bad_in;
    logic            carry_init;
    logic [3:0]      y_dig;
    logic [4:0]      sum;
    logic [3:0]      dig;
    logic            carry_nxt;

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);

    // Non-BCD digits anywhere in either operand poison the whole result.
    always_comb begin
        bad_in = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (x[4*k +: 4] > 4'd9 || y[4*k +: 4] > 4'd9) bad_in = 1'b1;
        end
    end

`ifdef BCD_SUB_EN
    // Subtraction as x + nines-complement(y) + ~borrow.
    assign carry_init = sub ? ~cin : cin;
    assign y_dig      = sub_r ? 4'd9 - y_sh[3:0] : y_sh[3:0];
`else
    logic unused_sub;
    assign unused_sub = sub ^ sub_r;
    assign carry_init = cin;
    assign y_dig      = y_sh[3:0];
`endif

    always_comb begin
        sum       = {1'b0, x_sh[3:0]} + {1'b0, y_dig} + {4'd0, carry};
        dig       = sum[3:0];
        carry_nxt = 1'b0;
        if (sum > 5'd9) begin
            dig       = 4'(sum - 5'd10);
            carry_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            x_sh  <= '0;
            y_sh  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sub_r <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        x_sh  <= x;
                        y_sh  <= y;
`ifdef BCD_SUB_EN
                        sub_r <= sub;
`else
                        sub_r <= 1'b0;
`endif
                        carry <= carry_init;
                        idx   <= '0;
                        err   <= bad_in;
                        s     <= '0;
                        cout  <= 1'b0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    // Result digits enter at the top and shift down into place.
                    x_sh  <= x_sh >> 4;
                    y_sh  <= y_sh >> 4;
                    s     <= {(err ? 4'd0 : dig), s[W-1:4]};
                    carry <= carry_nxt;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(DIGITS - 1)) begin
                        cout  <= carry_nxt & ~err;
                        idx   <= '0;
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4); subtract vectors depend on BCD_SUB_EN.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        err;

    int total = 0;
    int bad   = 0;
    int lat;
    bit stale;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns cycles from accept edge to out_valid.
    task automatic run_op(input logic [15:0] xa, input logic [15:0] yb, input logic c,
                          input logic sb, output int cycles);
        check("ready_before_op", {31'd0, in_ready}, 32'd1);
        x = xa; y = yb; cin = c; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 16'hffff; y = 16'hffff; cin = 1'b1; sub = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_take", {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_s_cout_err", {s, 14'd0, cout, err}, 32'h0);

        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat);
        check("add9999_lat", lat, 4);
        check("add9999_s", {16'd0, s}, 32'h0000);
        check("add9999_cout_err", {30'd0, cout, err}, 32'b10);
        check("done_not_ready", {31'd0, in_ready}, 32'd0);
        take_result();

        run_op(16'h1234, 16'h8766, 1'b1, 1'b0, lat);
        check("add1234_s", {16'd0, s}, 32'h0001);
        check("add1234_cout", {31'd0, cout}, 32'd1);
        take_result();

        run_op(16'h0045, 16'h0055, 1'b0, 1'b0, lat);
        check("add45_s_cout", {15'd0, cout, s}, 32'h0_0100);
        take_result();

`ifdef BCD_SUB_EN
        run_op(16'h0500, 16'h0123, 1'b0, 1'b1, lat);
        check("sub500_s", {16'd0, s}, 32'h0377);
        check("sub500_cout", {31'd0, cout}, 32'd1);
        take_result();
        run_op(16'h0123, 16'h0500, 1'b0, 1'b1, lat);
        check("sub123_s", {16'd0, s}, 32'h9623);
        check("sub123_cout", {31'd0, cout}, 32'd0);
        take_result();
        run_op(16'h0500, 16'h0123, 1'b1, 1'b1, lat);
        check("sub_borrow_s_cout", {15'd0, cout, s}, 32'h1_0376);
        take_result();
`else
        // sub is ignored: this is a plain add
        run_op(16'h0500, 16'h0123, 1'b0, 1'b1, lat);
        check("subign_s_cout", {15'd0, cout, s}, 32'h0_0623);
        take_result();
`endif

        run_op(16'h12a4, 16'h0001, 1'b0, 1'b0, lat);
        check("err_lat", lat, 4);
        check("err_flag", {31'd0, err}, 32'd1);
        check("err_s_cout", {15'd0, cout, s}, 32'h0);
        take_result();
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, lat);
        check("err_cleared", {15'd0, err, s}, 32'h0_0005);
        take_result();

        // Backpressure in DONE with a new operand already offered.
        run_op(16'h0045, 16'h0055, 1'b0, 1'b0, lat);
        x = 16'h1111; y = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_state", {14'd0, in_ready, out_valid, s}, 32'h1_0100);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_accept_next", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_next_lat", lat, 4);
        check("hold_next_s", {16'd0, s}, 32'h2222);
        take_result();

        // Reset while digit 2 is being processed.
        x = 16'h5555; y = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrun_reset_state", {14'd0, in_ready, out_valid, s}, 32'h2_0000);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_result", {31'd0, stale}, 32'd0);

        // Accept attempted while reset is asserted is dropped.
        x = 16'h0001; y = 16'h0001; in_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b1;
        check("reset_drops_accept", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 x  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 y  input  4*DIGITS  operand B, packed BCD.
REQ-008 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 s  output  4*DIGITS  packed BCD result.
REQ-013 cout  output  1  decimal carry-out (add) or no-borrow flag (subtract).
REQ-014 err  output  1  at least one captured operand digit exceeded 9.

Function
REQ-015 States: IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&in_ready, register x, y, cin, sub; clear digit index; go to RUN.
REQ-017 Add: result = x + y + cin mod 10^DIGITS; cout=1 when true sum >= 10^DIGITS.
REQ-018 Subtract: y digits replaced by 9-y_k, initial carry = ~cin; result = x - y - cin mod 10^DIGITS; cout=1 when x >= y+cin.
REQ-019 RUN processes one digit per cycle, LSD first: t = x_k + y'_k + c; if t>9, s_k = t-10 and c=1; else s_k = t and c=0.
REQ-020 After digit DIGITS-1 is written, cout = final carry; go to DONE.
REQ-021 Latency: out_valid rises exactly DIGITS cycles after the accept edge; initiation interval >= DIGITS+2 cycles.
REQ-022 DONE: s, cout and err stay stable until out_valid&out_ready; then return to IDLE.
REQ-023 No accept occurs in the same cycle as the result handshake.
REQ-024 in_valid, x, y, cin and sub are ignored while in_ready=0.
REQ-025 If any captured x or y digit is >9, err=1 and the block forces s=0 and cout=0; latency is unchanged.
REQ-026 err clears on the next accept.

Reset
REQ-027 rst_n=0 at a rising edge forces IDLE, s=0, cout=0, err=0, out_valid=0, in_ready=1 and digit index=0.
REQ-028 Reset mid-RUN or in DONE aborts the operation; no result is presented after reset.
REQ-029 A handshake in the cycle reset is asserted is discarded.

Configuration
REQ-030 Macro BCD_SUB_EN compiles in the subtract path (REQ-018).
REQ-031 Without BCD_SUB_EN, the sub port remains, is ignored, and is treated as 0; only addition is performed.

Verification
REQ-032 DIGITS=4, add 9999+0001, cin=0 -> s=0000, cout=1, err=0; out_valid exactly 4 cycles after accept.
REQ-033 Add 1234+8766, cin=1 -> s=0001, cout=1.
REQ-034 BCD_SUB_EN, sub=1: 0500-0123, cin=0 -> s=0377, cout=1; 0123-0500 -> s=9623, cout=0.
REQ-035 x=12A4 (hex digit A), y=0001 -> err=1, s=0000, cout=0, 4-cycle latency kept.
REQ-036 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> s stable, in_ready=0, no new capture; accept occurs the cycle after out_ready.
REQ-037 Drive rst_n=0 for 1 cycle in RUN (digit 2) -> next cycle in IDLE, out_valid=0, s=0; no stale result appears afterwards.
